// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered
// full/empty flags. Optional status outputs (count, almost_full,
// almost_empty) are compiled in when SYNC_FIFO_STATUS_EN is defined.
//
// Handshake: a write is accepted on a rising edge when wr_en=1 and either
// full=0 or a read is accepted on the same edge. A read is accepted when
// rd_en=1 and empty=0. The read word appears on rdata one cycle after the
// accepting edge and holds until the next accepted read. Requests that are
// not accepted leave every piece of state unchanged.
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   occ;
  logic [ADDR_WIDTH:0]   occ_next;
  logic                  rd_acc;
  logic                  wr_acc;

  // Acceptance decisions; a full FIFO still takes a write when a read frees a slot.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
  end

  // Next occupancy from the accepted operations.
  always_comb begin
    occ_next = occ;
    case ({wr_acc, rd_acc})
      2'b10:   occ_next = occ + ONE_C;
      2'b01:   occ_next = occ - ONE_C;
      default: occ_next = occ;
    endcase
  end

  // Storage array; contents are not reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers, occupancy, registered read data and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      occ   <= '0;
      rdata <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rptr  <= rptr + ADDR_WIDTH'(1);
        rdata <= mem[rptr];
      end
      occ   <= occ_next;
      full  <= (occ_next == DEPTH_C);
      empty <= (occ_next == '0);
    end
  end

`ifdef SYNC_FIFO_STATUS_EN
  // Threshold flags registered alongside full/empty from the same next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (occ_next >= (DEPTH_C - ONE_C));
      almost_empty <= (occ_next <= ONE_C);
    end
  end

  assign count = occ;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven vectors plus scoreboard-checked sequences for
// sync_fifo (fill/drain, overflow/underflow, simultaneous access, wrap,
// asynchronous mid-operation reset). Define SYNC_FIFO_STATUS_EN to also
// exercise the status outputs.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_STATUS_EN
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored words, queued read results, expected held rdata.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rdata;
  logic          saw_aa;

  typedef struct {
    logic          wr;
    logic [DW-1:0] wd;
    logic          rd;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;
  } vec_t;

  vec_t vecs[7];

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .wdata (wdata),
    .rd_en (rd_en),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
`ifdef SYNC_FIFO_STATUS_EN
    ,
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("full", 32'(full), 32'(model_q.size() == DEPTH));
`ifdef SYNC_FIFO_STATUS_EN
    check("count", 32'(count), 32'(model_q.size()));
    check("almost_full", 32'(almost_full), 32'(model_q.size() >= DEPTH - 1));
    check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= 1));
`endif
  endtask

  // One clock of stimulus; model updated before the edge, outputs checked #1 after.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    bit rd_ok;
    bit wr_ok;
    wr_en = w;
    wdata = d;
    rd_en = r;
    rd_ok = r && (model_q.size() != 0);
    wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) exp_rdata = exp_q.pop_front();
    if (rd_ok && rdata == 8'hAA) saw_aa = 1'b1;
    check("rdata", 32'(rdata), 32'(exp_rdata));
    check_status();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    exp_rdata = '0;
  endtask

  initial begin
    rst    = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wdata  = '0;
    saw_aa = 1'b0;
    model_reset();

    // Expected values for a short sequence straight out of reset.
    vecs[0] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1}; // read on empty ignored
    vecs[1] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0}; // first write
    vecs[2] = '{1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0}; // simultaneous, count stays 1
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1}; // drain last
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1}; // underflow holds rdata
    vecs[5] = '{1'b1, 8'h33, 1'b1, 8'h22, 1'b0, 1'b0}; // simultaneous on empty: write only
    vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1}; // no fall-through, read next cycle

    // Reset state.
    #12;
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_empty", 32'(empty), 32'h1);
    check("reset_full", 32'(full), 32'h0);
    rst = 1'b0;
    #2;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].wr, vecs[i].wd, vecs[i].rd);
      check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].rdata));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
    end

    // Fill 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'h1);
    // Overflow write is dropped.
    cycle(1'b1, 8'hAA, 1'b0);
    check("overflow_full", 32'(full), 32'h1);
    // Simultaneous on full: 0x01 out, 0x99 in behind 15 older entries.
    cycle(1'b1, 8'h99, 1'b1);
    check("full_simul_rdata", 32'(rdata), 32'h01);
    check("full_simul_full", 32'(full), 32'h1);
    // Drain 16; order checked by scoreboard.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drain_last", 32'(rdata), 32'h99);
    check("drain_empty", 32'(empty), 32'h1);
    check("no_aa_drained", 32'(saw_aa), 32'h0);
    // Underflow holds rdata.
    cycle(1'b0, 8'h00, 1'b1);
    check("underflow_hold", 32'(rdata), 32'h99);

    // Four entries, ten simultaneous cycles, then drain.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(8'h50 + i), 1'b1);
      check("steady_occ", 32'(model_q.size()), 32'd4);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    check("steady_last", 32'(rdata), 32'h59);

    // Wrap-around: write/read 10, then write/read 12, values 0x20+i.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);
    check("wrap_last", 32'(rdata), 32'h2B);

    // Random traffic checked only by the scoreboard.
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Mid-operation asynchronous reset between edges.
    while (model_q.size() != 0) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_empty", 32'(empty), 32'h1);
    check("midrst_full", 32'(full), 32'h0);
    check("midrst_rdata", 32'(rdata), 32'h0);
    model_reset();
    #1 rst = 1'b0;
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("post_rst_read", 32'(rdata), 32'h55);
    check("post_rst_empty", 32'(empty), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
